// File: rtl/poly_tone_pkg.sv
// Shared constants, note typedef and the half-period table for poly_tone_synth.
package poly_tone_pkg;

  localparam int NOTE_COUNT = 16;

  typedef logic [3:0] note_t;

  // Chromatic C4..D#5 in centi-hertz.
  function automatic int unsigned note_fc(input note_t n);
    case (n)
      4'd0:    return 26163;
      4'd1:    return 27718;
      4'd2:    return 29366;
      4'd3:    return 31113;
      4'd4:    return 32963;
      4'd5:    return 34923;
      4'd6:    return 36999;
      4'd7:    return 39200;
      4'd8:    return 41530;
      4'd9:    return 44000;
      4'd10:   return 46616;
      4'd11:   return 49388;
      4'd12:   return 52325;
      4'd13:   return 55437;
      4'd14:   return 58733;
      default: return 62225;
    endcase
  endfunction

  // Half period in clocks, rounded to nearest: clk_hz / (2 * f).
  function automatic int unsigned hp(input note_t n, input longint unsigned clk_hz);
    longint unsigned fc;
    fc = 64'(note_fc(n));
    return 32'((clk_hz * 64'd100 + fc) / (64'd2 * fc));
  endfunction

  // C4 has the longest half period, so it sizes every voice counter.
  function automatic int cnt_w(input longint unsigned clk_hz);
    return $clog2(64'(hp(4'd0, clk_hz)) + 64'd1);
  endfunction

endpackage

// File: rtl/poly_tone_synth_if.sv
// Keyboard-side bus of poly_tone_synth: per-voice note/hush in, per-voice tone and speaker out.
interface poly_tone_synth_if #(
  parameter int NUM_VOICES = 4
);

  logic [4*NUM_VOICES-1:0] note;
  logic [NUM_VOICES-1:0]   hush;
  logic [NUM_VOICES-1:0]   tone;
  logic                    speaker;

  modport master (output note, hush, input tone, speaker);
  modport slave  (input note, hush, output tone, speaker);

endinterface

// File: rtl/poly_tone_synth_voice.sv
// tone_voice: one square-wave voice; note/hush registered, tone 1 clock behind its counter; no backpressure.
// With TONE_DECAY_EN the voice carries an amplitude envelope stepped by a shared decay tick.
module tone_voice
  import poly_tone_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int AMP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  note_t            note,
  input  logic             hush,
`ifdef TONE_DECAY_EN
  input  logic             decay_tick,
`endif
  output logic             tone,
  output logic [AMP_W-1:0] lvl
);

  localparam int CNT_W = cnt_w(CLK_HZ);
  localparam logic [AMP_W-1:0] AMP_FULL = '1;

  logic [CNT_W-1:0] hp_m1 [NOTE_COUNT];
  for (genvar i = 0; i < NOTE_COUNT; i++) begin : g_hp
    assign hp_m1[i] = CNT_W'(hp(note_t'(i), CLK_HZ) - 1);
  end

  note_t            note_q;
  logic             hush_q;
  logic [CNT_W-1:0] cnt;
  logic             chg;

  assign chg = (note != note_q);

  // A new note restarts the period from the capturing edge; hush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q <= '0;
      hush_q <= 1'b0;
      cnt    <= '0;
      tone   <= 1'b0;
    end else begin
      note_q <= note;
      hush_q <= hush;
      if (hush_q) begin
        cnt  <= '0;
        tone <= 1'b0;
      end else if (chg) begin
        cnt <= '0;
      end else if (cnt == hp_m1[note_q]) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef TONE_DECAY_EN
  logic [AMP_W-1:0] amp;

  // Each strike (hush release or note change) reloads the envelope to full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp <= AMP_FULL;
    end else if ((hush_q && !hush) || chg) begin
      amp <= AMP_FULL;
    end else if (decay_tick && (amp != '0)) begin
      amp <= amp - 1'b1;
    end
  end

  assign lvl = (tone && !hush_q) ? amp : '0;
`else
  assign lvl = (tone && !hush_q) ? AMP_FULL : '0;
`endif

endmodule

// File: rtl/poly_tone_synth.sv
// poly_tone_synth: NUM_VOICES square-wave voices mixed by a 1st-order sigma-delta onto one speaker bit.
// Speaker trails tone by 1 clock, no backpressure; optional envelope decay under TONE_DECAY_EN.
module poly_tone_synth
  import poly_tone_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int AMP_W      = 4,
  parameter int DECAY_DIV  = 1000000
) (
  input logic               clk,
  input logic               rst_n,
  poly_tone_synth_if.slave  bus
);

  localparam int LVL_W = AMP_W + $clog2(NUM_VOICES + 1);
  localparam int ACC_W = LVL_W + 1;
  localparam logic [ACC_W-1:0] FS = ACC_W'(NUM_VOICES * (2**AMP_W - 1));

  if (NUM_VOICES < 1 || NUM_VOICES > 8 || DECAY_DIV < 1) begin : g_bad_cfg
    $error("poly_tone_synth: parameter out of range");
  end

`ifdef TONE_DECAY_EN
  localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic             decay_tick;

  assign decay_tick = (pre == PRE_W'(DECAY_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else begin
      pre <= decay_tick ? '0 : pre + 1'b1;
    end
  end
`endif

  logic [NUM_VOICES-1:0] tone_w;
  logic [AMP_W-1:0]      lvl [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .CLK_HZ (CLK_HZ),
      .AMP_W  (AMP_W)
    ) u_voice (
      .clk        (clk),
      .rst_n      (rst_n),
      .note       (bus.note[4*v +: 4]),
      .hush       (bus.hush[v]),
`ifdef TONE_DECAY_EN
      .decay_tick (decay_tick),
`endif
      .tone       (tone_w[v]),
      .lvl        (lvl[v])
    );
  end

  logic [LVL_W-1:0] level;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic             speaker_q;

  always_comb begin
    level = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      level = level + LVL_W'(lvl[v]);
    end
  end

  // speaker_q always equals (acc >= FS), so acc_base stays in [0, FS) and acc_next below 2*FS.
  always_comb begin
    acc_base = speaker_q ? (acc - FS) : acc;
    acc_next = acc_base + ACC_W'(level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      speaker_q <= 1'b0;
    end else begin
      acc       <= acc_next;
      speaker_q <= (acc_next >= FS);
    end
  end

  assign bus.tone    = tone_w;
  assign bus.speaker = speaker_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth at a scaled-down CLK_HZ so every half period is a few clocks.
module tb_poly_tone_synth;
  import poly_tone_pkg::*;

  localparam int NV   = 4;
  localparam int CLKF = 10000;
  localparam int AMPW = 4;
  localparam int DDIV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  poly_tone_synth_if #(.NUM_VOICES(NV)) bus ();

  poly_tone_synth #(
    .NUM_VOICES (NV),
    .CLK_HZ     (CLKF),
    .AMP_W      (AMPW),
    .DECAY_DIV  (DDIV)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int v;
    int note;
    int hp_exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until tone[v]==lvl; n = steps taken, -1 if the budget ran out.
  task automatic wait_tone(input int v, input logic lvl, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.tone[v] == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  // Expected tone j edges after the edge that starts a voice counting from 0.
  function automatic int exp_t(input int j, input int hpv);
    return (j < 0) ? 0 : ((j / hpv) % 2);
  endfunction

  initial begin
    vec_t            tbl [8];
    int              hp4 [4];
    int              n;
    int              ones;
    longint          lsum;
    longint unsigned clk100;
    logic [NV-1:0]   others;

    tbl[0] = '{v:0, note:9,  hp_exp:11};
    tbl[1] = '{v:1, note:0,  hp_exp:19};
    tbl[2] = '{v:2, note:4,  hp_exp:15};
    tbl[3] = '{v:3, note:7,  hp_exp:13};
    tbl[4] = '{v:0, note:12, hp_exp:10};
    tbl[5] = '{v:1, note:15, hp_exp:8};
    tbl[6] = '{v:2, note:3,  hp_exp:16};
    tbl[7] = '{v:3, note:11, hp_exp:10};
    hp4[0] = 19; hp4[1] = 15; hp4[2] = 13; hp4[3] = 10;

    clk100 = 64'd100000000;
    check("hp_c4_100m",  hp(4'd0,  clk100), 191110);
    check("hp_a4_100m",  hp(4'd9,  clk100), 113636);
    check("hp_ds5_100m", hp(4'd15, clk100), 80354);
    check("cntw_100m",   cnt_w(clk100), 18);

    bus.note = '0;
    bus.hush = '1;
    #100;
    check("rst_tone", bus.tone, 0);
    check("rst_spk",  bus.speaker, 0);
    check("rst_acc",  u_dut.acc, 0);
    rst_n = 1'b1;
    steps(3);

    // Per-voice half period: first rise after release, then fall and rise again.
    for (int i = 0; i < 8; i++) begin
      bus.hush = '1;
      bus.note[4*tbl[i].v +: 4] = 4'(tbl[i].note);
      steps(3);
      bus.hush[tbl[i].v] = 1'b0;
      wait_tone(tbl[i].v, 1'b1, 200, n);
      check("tbl_first_rise", n - 1, tbl[i].hp_exp);
      wait_tone(tbl[i].v, 1'b0, 200, n);
      check("tbl_fall", n, tbl[i].hp_exp);
      wait_tone(tbl[i].v, 1'b1, 200, n);
      check("tbl_rise", n, tbl[i].hp_exp);
      others = ~(NV'(1) << tbl[i].v);
      check("tbl_others_quiet", bus.tone & others, 0);
    end

    // Note change mid-period: level held, new period counted from the capturing edge.
    bus.hush = '1;
    bus.note[3:0] = 4'd9;
    steps(3);
    bus.hush[0] = 1'b0;
    wait_tone(0, 1'b1, 200, n);
    check("chg_pre_rise", n - 1, 11);
    steps(4);
    bus.note[3:0] = 4'd0;
    wait_tone(0, 1'b0, 200, n);
    check("chg_fall_after", n - 1, 19);
    wait_tone(0, 1'b1, 200, n);
    check("chg_next_rise", n, 19);

    // All voices in phase at full amplitude: speaker is tone delayed by one clock.
    bus.hush = '1;
    bus.note = {4'd4, 4'd4, 4'd4, 4'd4};
    steps(3);
    bus.hush = '0;
    for (int k = 1; k <= 3*15 + 2; k++) begin
      step();
      check("inphase_tone", bus.tone, (exp_t(k - 1, 15) != 0) ? 4'hF : 4'h0);
      check("inphase_spk",  bus.speaker, exp_t(k - 2, 15));
    end

    // Hush everything while high: tone drops on the second edge, speaker with it.
    bus.hush = '1;
    step();
    check("hush_tone_1clk", bus.tone, 4'hF);
    step();
    check("hush_tone_2clk", bus.tone, 0);
    check("hush_spk_2clk",  bus.speaker, 0);

    // Simultaneous note change and hush: hush wins.
    bus.note[3:0] = 4'd9;
    steps(3);
    bus.hush[0] = 1'b0;
    wait_tone(0, 1'b1, 200, n);
    check("sim_rise", n - 1, 11);
    bus.note[3:0] = 4'd2;
    bus.hush[0] = 1'b1;
    steps(2);
    check("sim_tone", bus.tone[0], 0);
    steps(5);
    check("sim_tone_held", bus.tone, 0);
    check("sim_spk", bus.speaker, 0);

    // One voice at full amplitude out of four: speaker duty 25% of its high time.
    bus.note[11:8] = 4'd9;
    steps(3);
    bus.hush[2] = 1'b0;
    wait_tone(2, 1'b1, 200, n);
    check("duty1_rise", n - 1, 11);
    ones = 0;
    for (int k = 0; k < 220; k++) begin
      step();
      ones += int'(bus.speaker);
    end
    check_rng("duty1_ones", ones, 26, 29);

    // Chord C4 E4 G4 C5: speaker density tracks the summed tone level.
    bus.hush = '1;
    steps(3);
    bus.note = {4'd12, 4'd7, 4'd4, 4'd0};
    bus.hush = '0;
    ones = 0;
    lsum = 0;
    for (int k = 1; k <= 600; k++) begin
      step();
      ones += int'(bus.speaker);
      for (int v = 0; v < 4; v++) lsum += 15 * exp_t(k - 2, hp4[v]);
    end
    check_rng("chord_ones", ones, lsum / 60 - 2, lsum / 60 + 2);

    // Asynchronous reset mid-tone, then restart of voice 1 (E4).
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tone", bus.tone, 0);
    check("arst_spk",  bus.speaker, 0);
    check("arst_acc",  u_dut.acc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tone(1, 1'b1, 200, n);
    check("arst_restart_rise", n - 1, 15);
    wait_tone(1, 1'b0, 200, n);
    check("arst_restart_fall", n, 15);

`ifdef TONE_DECAY_EN
    // Envelope: 15 ticks of DDIV clocks take amplitude to zero, leaving speaker silent.
    @(negedge clk);
    rst_n = 1'b0;
    bus.note = '0;
    bus.hush = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      ones += int'(bus.speaker);
    end
    check_rng("decay_early_ones", ones, 1, 60);
    steps(100);
    ones = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      ones += int'(bus.speaker);
    end
    check("decay_silent_ones", ones, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
